// File: rtl/score_tracker.sv
// score_tracker: accumulates game score with a streak bonus, tracks the level
// incrementally (no divider), and converts the score to four BCD digits with a
// sequential double-dabble shifter.
//
// Handshake: a placement is accepted on a rising edge where clear_valid and
// in_ready are both high and score_clear is low. in_ready is high only in IDLE.
// A clear_valid seen while in_ready is low is dropped, not queued. bcd_valid
// is a one-cycle pulse and needs no acknowledge.
module score_tracker #(
  parameter int SCORE_MAX       = 9999,
  parameter int LINES_PER_LEVEL = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_valid,
  input  logic [4:0] num_cleared,
  output logic       in_ready,
  input  logic       score_clear,
  input  logic [3:0] debug_level,
  output logic [13:0] score,
  output logic [1:0] streaks,
  output logic [3:0] level,
  output logic [3:0] dig4,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic       bcd_valid
);

  localparam logic [13:0] SMAX = 14'(SCORE_MAX);
  localparam logic [14:0] LPL  = 15'(LINES_PER_LEVEL);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic [13:0] score_q, score_d;
  logic [1:0]  streaks_q, streaks_d;
  logic [3:0]  quot_q, quot_d;
  logic [13:0] rem_q, rem_d;
  logic [29:0] shreg_q, shreg_d;   // {bcd[15:0], bin[13:0]}
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dig_q, dig_d;
  logic        bcd_valid_q, bcd_valid_d;

  logic        accept;
  logic [2:0]  nc_clip;
  logic [2:0]  pts;
  logic [2:0]  add_pts;
  logic [14:0] sum_full;
  logic [13:0] score_new;
  logic [14:0] rem_sum;
  logic [15:0] adj_bcd;
  logic [4:0]  lvl_sum;

  assign accept = clear_valid && in_ready && !score_clear;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one conversion of 14 shifts per accepted placement
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CONV;
      CONV: if (cnt_q == 4'd13) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (score_clear) state_d = IDLE;
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Points for this placement; saturation clips the amount actually added
  always_comb begin
    nc_clip   = (num_cleared > 5'd4) ? 3'd4 : num_cleared[2:0];
    pts       = nc_clip + {1'b0, streaks_q};
    sum_full  = {1'b0, score_q} + 15'(pts);
    if (sum_full >= {1'b0, SMAX}) begin
      add_pts   = 3'(SMAX - score_q);
      score_new = SMAX;
    end else begin
      add_pts   = pts;
      score_new = sum_full[13:0];
    end
    rem_sum = {1'b0, rem_q} + 15'(add_pts);
  end

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  always_comb begin
    adj_bcd = shreg_q[29:14];
    for (int i = 0; i < 4; i++) begin
      if (adj_bcd[i*4 +: 4] >= 4'd5) adj_bcd[i*4 +: 4] = adj_bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Datapath next values: clear, accept, or one conversion step
  always_comb begin
    score_d     = score_q;
    streaks_d   = streaks_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    bcd_valid_d = 1'b0;
    if (score_clear) begin
      score_d   = '0;
      streaks_d = '0;
      quot_d    = '0;
      rem_d     = '0;
      shreg_d   = '0;
      cnt_d     = '0;
      dig_d     = '0;
    end else if (accept) begin
      score_d   = score_new;
      streaks_d = (num_cleared == 5'd0) ? 2'd0 :
                  (streaks_q == 2'd3)   ? 2'd3 : streaks_q + 2'd1;
      if (rem_sum >= LPL) begin
        rem_d  = 14'(rem_sum - LPL);
        quot_d = (quot_q == 4'd15) ? quot_q : quot_q + 4'd1;
      end else begin
        rem_d  = rem_sum[13:0];
      end
      shreg_d = {16'd0, score_new};
      cnt_d   = 4'd0;
    end else if (state_q == CONV) begin
      shreg_d = {adj_bcd, shreg_q[13:0]} << 1;
      cnt_d   = cnt_q + 4'd1;
      if (cnt_q == 4'd13) begin
        dig_d       = shreg_d[29:14];
        bcd_valid_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q     <= '0;
      streaks_q   <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dig_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      streaks_q   <= streaks_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  // Level: debug offset if it fits in 4 bits, otherwise the plain quotient
  always_comb begin
    lvl_sum = {1'b0, quot_q} + {1'b0, debug_level};
    level   = (lvl_sum < 5'd16) ? lvl_sum[3:0] : quot_q;
  end

  assign score     = score_q;
  assign streaks   = streaks_q;
  assign dig4      = dig_q[15:12];
  assign dig3      = dig_q[11:8];
  assign dig2      = dig_q[7:4];
  assign dig1      = dig_q[3:0];
  assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_score_tracker.sv
// Testbench for score_tracker: directed placements, an expected-digit queue
// per instance checked by a monitor on bcd_valid, and direct checks of score,
// streaks, level and handshake timing.
module tb_score_tracker;

  localparam int LPL  = 20;
  localparam int MAX1 = 9999;
  localparam int MAX2 = 30;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A (default ceiling)
  logic        clear_valid, score_clear, in_ready, bcd_valid;
  logic [4:0]  num_cleared;
  logic [3:0]  debug_level, level, dig4, dig3, dig2, dig1;
  logic [13:0] score;
  logic [1:0]  streaks;

  // Instance B (ceiling 30)
  logic        cv_b, sc_b, in_ready_b, bcd_valid_b;
  logic [4:0]  nc_b;
  logic [3:0]  dbg_b, level_b, d4_b, d3_b, d2_b, d1_b;
  logic [13:0] score_b;
  logic [1:0]  streaks_b;

  score_tracker #(.SCORE_MAX(MAX1), .LINES_PER_LEVEL(LPL)) dut (
    .clk(clk), .rst(rst), .clear_valid(clear_valid), .num_cleared(num_cleared),
    .in_ready(in_ready), .score_clear(score_clear), .debug_level(debug_level),
    .score(score), .streaks(streaks), .level(level),
    .dig4(dig4), .dig3(dig3), .dig2(dig2), .dig1(dig1), .bcd_valid(bcd_valid)
  );

  score_tracker #(.SCORE_MAX(MAX2), .LINES_PER_LEVEL(LPL)) dut_b (
    .clk(clk), .rst(rst), .clear_valid(cv_b), .num_cleared(nc_b),
    .in_ready(in_ready_b), .score_clear(sc_b), .debug_level(dbg_b),
    .score(score_b), .streaks(streaks_b), .level(level_b),
    .dig4(d4_b), .dig3(d3_b), .dig2(d2_b), .dig1(d1_b), .bcd_valid(bcd_valid_b)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];

  // Reference model state for each instance
  int m_sc, m_st, m_q, m_r;
  int b_sc, b_st, b_q, b_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input int smax, input int nc, inout int sc, inout int st,
                            inout int q, inout int r);
    int p, add;
    p = ((nc > 4) ? 4 : nc) + st;
    if (sc + p >= smax) add = smax - sc;
    else                add = p;
    sc = sc + add;
    r  = r + add;
    if (r >= LPL) begin
      r = r - LPL;
      if (q < 15) q = q + 1;
    end
    st = (nc == 0) ? 0 : ((st < 3) ? st + 1 : 3);
  endtask

  // Monitor: every bcd_valid pulse pops one expected digit set
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst) begin
      if (bcd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL bcd_valid_a: unexpected pulse, digits %h", {dig4, dig3, dig2, dig1});
        end else begin
          e = exp_q.pop_front();
          check("digits_a", {16'd0, dig4, dig3, dig2, dig1}, {16'd0, e});
        end
      end
      if (bcd_valid_b) begin
        if (exp2_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL bcd_valid_b: unexpected pulse, digits %h", {d4_b, d3_b, d2_b, d1_b});
        end else begin
          e = exp2_q.pop_front();
          check("digits_b", {16'd0, d4_b, d3_b, d2_b, d1_b}, {16'd0, e});
        end
      end
    end
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic wait_idle_a();
    int w = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_a timeout: got 0 expected 1");
    end
  endtask

  task automatic wait_idle_b();
    int w = 0;
    while (!in_ready_b && w < 40) begin @(negedge clk); w++; end
    if (!in_ready_b) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_b timeout: got 0 expected 1");
    end
  endtask

  task automatic acc_a(input int nc, input bit push);
    wait_idle_a();
    clear_valid = 1'b1;
    num_cleared = 5'(nc);
    @(negedge clk);
    clear_valid = 1'b0;
    model_step(MAX1, nc, m_sc, m_st, m_q, m_r);
    check("score_a", {18'd0, score}, m_sc);
    check("streaks_a", {30'd0, streaks}, m_st);
    if (push) exp_q.push_back(to_bcd(m_sc));
  endtask

  task automatic acc_b(input int nc);
    wait_idle_b();
    cv_b = 1'b1;
    nc_b = 5'(nc);
    @(negedge clk);
    cv_b = 1'b0;
    model_step(MAX2, nc, b_sc, b_st, b_q, b_r);
    check("score_b", {18'd0, score_b}, b_sc);
    check("streaks_b", {30'd0, streaks_b}, b_st);
    exp2_q.push_back(to_bcd(b_sc));
  endtask

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int cnt;
    logic [4:0] b30_step[8];
    rst = 1'b1;
    clear_valid = 0; num_cleared = 0; score_clear = 0; debug_level = 0;
    cv_b = 0; nc_b = 0; sc_b = 0; dbg_b = 0;
    m_sc = 0; m_st = 0; m_q = 0; m_r = 0;
    b_sc = 0; b_st = 0; b_q = 0; b_r = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_score", {18'd0, score}, 0);
    check("rst_streaks", {30'd0, streaks}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_bcd_valid", {31'd0, bcd_valid}, 0);
    check("rst_digits", {16'd0, dig4, dig3, dig2, dig1}, 0);
    check("rst_level", {28'd0, level}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single accept, conversion latency
    acc_a(1, 1'b1);
    check("t1_score", {18'd0, score}, 1);
    check("t1_streaks", {30'd0, streaks}, 1);
    cnt = 0;
    while (!in_ready && cnt < 40) begin cnt++; @(negedge clk); end
    check("t1_busy_cycles", cnt, 14);
    check("t1_bcd_valid", {31'd0, bcd_valid}, 1);
    check("t1_level", {28'd0, level}, 0);
    @(negedge clk);
    check("t1_bcd_valid_one_cycle", {31'd0, bcd_valid}, 0);

    // 2: streak bonus
    acc_a(1, 1'b1);
    check("t2_score_3", {18'd0, score}, 3);
    acc_a(1, 1'b1);
    check("t2_score_6", {18'd0, score}, 6);
    acc_a(4, 1'b1);
    check("t2_score_13", {18'd0, score}, 13);
    check("t2_streaks_3", {30'd0, streaks}, 3);
    acc_a(0, 1'b1);
    check("t2_score_16", {18'd0, score}, 16);
    check("t2_streaks_0", {30'd0, streaks}, 0);

    // 3: level crossing
    wait_idle_a();
    debug_level = 4'd2;
    acc_a(4, 1'b1);
    check("t3_score", {18'd0, score}, 20);
    check("t3_quot", {28'd0, dut.quot_q}, 1);
    check("t3_rem", {18'd0, dut.rem_q}, 0);
    check("t3_level_dbg2", {28'd0, level}, 3);
    debug_level = 4'd15;
    #1;
    check("t3_level_fallback", {28'd0, level}, 1);

    // 4: reach 1234, then an accept strobed mid-conversion is dropped
    acc_a(4, 1'b1);
    acc_a(4, 1'b1);
    check("t4_score_31", {18'd0, score}, 31);
    for (int i = 0; i < 171; i++) acc_a(4, 1'b1);
    acc_a(3, 1'b1);
    check("t4_score_1234", {18'd0, score}, 1234);
    repeat (3) @(negedge clk);
    clear_valid = 1'b1; num_cleared = 5'd4;
    @(negedge clk);
    clear_valid = 1'b0;
    wait_idle_a();
    check("t4_score_held", {18'd0, score}, 1234);
    check("t4_streaks", {30'd0, streaks}, 3);
    check("t4_digits", {16'd0, dig4, dig3, dig2, dig1}, 32'h1234);
    check("t4_quot_sat", {28'd0, dut.quot_q}, 15);
    check("t4_level", {28'd0, level}, 15);

    // 6: score_clear five cycles into a conversion
    debug_level = 4'd0;
    acc_a(2, 1'b0);
    check("t6_score_1239", {18'd0, score}, 1239);
    repeat (4) @(negedge clk);
    score_clear = 1'b1;
    @(negedge clk);
    score_clear = 1'b0;
    m_sc = 0; m_st = 0; m_q = 0; m_r = 0;
    check("t6_clr_score", {18'd0, score}, 0);
    check("t6_clr_streaks", {30'd0, streaks}, 0);
    check("t6_clr_level", {28'd0, level}, 0);
    check("t6_clr_digits", {16'd0, dig4, dig3, dig2, dig1}, 0);
    check("t6_clr_in_ready", {31'd0, in_ready}, 1);
    check("t6_clr_bcd_valid", {31'd0, bcd_valid}, 0);
    repeat (20) @(negedge clk);
    score_clear = 1'b1; clear_valid = 1'b1; num_cleared = 5'd4;
    @(negedge clk);
    score_clear = 1'b0; clear_valid = 1'b0;
    check("t6_both_score", {18'd0, score}, 0);
    check("t6_both_in_ready", {31'd0, in_ready}, 1);

    // Asynchronous reset mid-conversion
    acc_a(4, 1'b1);
    check("t6_score_4", {18'd0, score}, 4);
    wait_idle_a();
    check("t6_digits_4", {16'd0, dig4, dig3, dig2, dig1}, 32'h0004);
    acc_a(4, 1'b0);
    check("t6_score_9", {18'd0, score}, 9);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_score", {18'd0, score}, 0);
    check("t6_arst_streaks", {30'd0, streaks}, 0);
    check("t6_arst_digits", {16'd0, dig4, dig3, dig2, dig1}, 0);
    check("t6_arst_in_ready", {31'd0, in_ready}, 1);
    check("t6_arst_bcd_valid", {31'd0, bcd_valid}, 0);
    check("t6_arst_quot", {28'd0, dut.quot_q}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_sc = 0; m_st = 0; m_q = 0; m_r = 0;
    @(negedge clk);

    // 5: saturation at 30 (instance B): 4, 9, 15, 22, 29, 30, 30, 30
    b30_step = '{5'd4, 5'd9, 5'd15, 5'd22, 5'd29, 5'd30, 5'd30, 5'd30};
    for (int i = 0; i < 8; i++) begin
      acc_b(4);
      check("t5_step_score", {18'd0, score_b}, {27'd0, b30_step[i]});
    end
    wait_idle_b();
    check("t5_score", {18'd0, score_b}, 30);
    check("t5_streaks", {30'd0, streaks_b}, 3);
    check("t5_quot", {28'd0, dut_b.quot_q}, 1);
    check("t5_level", {28'd0, level_b}, 1);
    check("t5_digits", {16'd0, d4_b, d3_b, d2_b, d1_b}, 32'h0030);

    // All expected digit sets delivered
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp2_q_drained", exp2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
